// File: rtl/student_sub16_serial.sv
// Bit-serial subtractor: out = a - b, one bit per clock, LSB first.
// Operands are captured on an accepted start; the result and its flags are
// registered and held until the next operation completes.
module student_sub16_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             zero,
  output logic             neg
);

  // Counter only needs to reach WIDTH-1; guard the degenerate WIDTH=1 case.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  // Holds the WIDTH-1 already-computed bits; the final bit is appended on the
  // completion edge, so no register bit is ever left unused.
  logic [WIDTH-2:0]   res_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               br_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   out_q;
  logic               borrow_q;
  logic               zero_q;
  logic               neg_q;

  // One full-subtractor cell working on the current LSBs.
  logic             x_bit;
  logic             y_bit;
  logic             diff_d;
  logic             br_d;
  logic             last_bit;
  logic [WIDTH-1:0] result_d;

  assign x_bit    = a_sh_q[0];
  assign y_bit    = b_sh_q[0];
  assign diff_d   = x_bit ^ y_bit ^ br_q;
  assign br_d     = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign result_d = {diff_d, res_sh_q};

  // Control FSM and datapath; every output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register here sample the
      // pre-edge values of the others, so shift/borrow/count stay in lockstep.
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= {diff_d, res_sh_q[WIDTH-2:1]};
          br_q     <= br_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            out_q    <= result_d;
            borrow_q <= br_d;
            zero_q   <= (result_d == '0);
            neg_q    <= diff_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign out    = out_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign neg    = neg_q;

endmodule

// File: tb/tb_student_sub16_serial.sv
// Bench for the bit-serial subtractor: a driver issues operations and pushes
// the expected result into a scoreboard; a monitor checks each done pulse.
module tb_student_sub16_serial;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             zero;
  logic             neg;

  student_sub16_serial #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .out    (out),
    .borrow (borrow),
    .zero   (zero),
    .neg    (neg)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic             zero;
    logic             neg;
    int               due;
  } exp_t;

  exp_t sb[$];
  exp_t prev;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index: after rising edge n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain modular subtraction and an unsigned compare.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input int due);
    exp_t e;
    int unsigned ua = av;
    int unsigned ub = bv;
    e.res    = WIDTH'((ua + (1 << WIDTH) - ub) % (1 << WIDTH));
    e.borrow = (ua < ub);
    e.zero   = (e.res == 0);
    e.neg    = e.res[WIDTH-1];
    e.due    = due;
    return e;
  endfunction

  // Monitor: held outputs during RUN, completion results, pulse timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (busy) begin
        busy_cnt++;
        check("hold_out", out, prev.res);
        check("hold_borrow", borrow, prev.borrow);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out", out, e.res);
          check("borrow", borrow, e.borrow);
          check("zero", zero, e.zero);
          check("neg", neg, e.neg);
          check("done_cycle", cyc, e.due);
          check("busy_len", busy_cnt, WIDTH);
          prev = e;
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one operation; called while the DUT is in IDLE or DONE. Returns
  // just after the completion edge, i.e. inside the DONE cycle.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit noise);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(av, bv, cyc + WIDTH));
    start = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (noise) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_out"}, out, 0);
    check({tag, "_borrow"}, borrow, 0);
    check({tag, "_zero"}, zero, 0);
    check({tag, "_neg"}, neg, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    prev  = model('0, '0, 0);
    prev.zero = 1'b0;  // reset leaves zero low even though out is 0
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    gap(3);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    issue(16'h0000, 16'h0000, 0);
    gap(2);
    issue(16'h0000, 16'h0001, 0);
    issue(16'hFFFF, 16'hFFFF, 0);
    gap(1);
    issue(16'hAAAA, 16'h5555, 0);
    issue(16'h1234, 16'h9876, 0);
    issue(16'h3CC3, 16'h0FF0, 0);
    gap(1);
    // Inputs and start toggled throughout RUN must be ignored.
    issue(16'hBEEF, 16'h1234, 1);
    // start held through DONE: next operation with no idle gap.
    issue(16'h0005, 16'h0007, 0);
    gap(1);

    // Abort mid-run: reset after bit 7, outputs clear immediately.
    a = 16'h7777;
    b = 16'h1111;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    gap(7);
    rst_n = 1'b0;
    #1;
    sb.delete();
    busy_cnt = 0;
    prev = model('0, '0, 0);
    prev.zero = 1'b0;
    check_reset_outputs("abort");
    gap(3);
    check_reset_outputs("abort_hold");
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0010, 16'h0001, 0);
    gap(1);

    // Randomized operations with random noise and gaps.
    for (int n = 0; n < 40; n++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      gap($urandom_range(0, 2));
    end

    // Drain: every issued operation must have completed.
    for (int i = 0; i < 2 * WIDTH && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
